frame_fft_sequencer: RTL and testbench

Frame-synchronous controller for the visualizer's audio path. On each rising edge of VGA vsync it starts one microphone capture, then one FFT pass. It collects the 16 streamed magnitude bins into a shadow bank and commits them atomically to the bar registers read by the VGA renderer. A watchdog and an overrun counter keep a stalled sampler or FFT from freezing the display.

---
 rtl/frame_fft_sequencer_if.sv | 32 +++
 rtl/frame_fft_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_frame_fft_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_fft_sequencer_if.sv
// Handshake and result bundle between the frame sequencer and its
// neighbours (sampler, FFT engine, VGA renderer).
// master: the environment driving vsync/sampler/FFT status.
// slave:  the sequencer itself.
interface frame_fft_sequencer_if #(
  parameter int MAG_W = 18
);
  logic               enable;
  logic               vsync;
  logic               samp_start;
  logic               samp_done;
  logic               fft_start;
  logic               bin_valid;
  logic [3:0]         bin_idx;
  logic [MAG_W-1:0]   bin_mag;
  logic               fft_done;
  logic [16*MAG_W-1:0] bars;
  logic               frame_done;
  logic               err_timeout;
  logic [7:0]         overrun_cnt;
  logic               busy;

  modport master (
    output enable, vsync, samp_done, bin_valid, bin_idx, bin_mag, fft_done,
    input  samp_start, fft_start, bars, frame_done, err_timeout, overrun_cnt, busy
  );

  modport slave (
    input  enable, vsync, samp_done, bin_valid, bin_idx, bin_mag, fft_done,
    output samp_start, fft_start, bars, frame_done, err_timeout, overrun_cnt, busy
  );
endinterface

// File: rtl/frame_fft_sequencer.sv
// Frame-synchronous audio sequencer: each vsync rise runs one capture and
// one FFT pass, collects 16 magnitude bins into a shadow bank and commits
// them to the bar registers in a single cycle. A watchdog aborts a stalled
// capture or FFT; vsync rises seen while busy are counted, not queued.
// Optional build macro: FFT_SEQ_PEAK_DECAY_EN (peak-hold bars that fall by
// at most DECAY per frame).
module frame_fft_sequencer #(
  parameter int MAG_W   = 18,
  parameter int TIMEOUT = 1_000_000,
  parameter int DECAY   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_fft_sequencer_if.slave bus
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_SAMP = 3'd1,
    SAMPLING   = 3'd2,
    START_FFT  = 3'd3,
    FFT        = 3'd4,
    COMMIT     = 3'd5
  } state_t;

  state_t           state;
  logic             vsync_q;
  logic             vs_rise;
  logic [WD_W-1:0]  wd_cnt;
  logic [7:0]       overrun_cnt;
  logic             frame_done;
  logic             err_timeout;
  logic [MAG_W-1:0] shadow [16];
  logic [MAG_W-1:0] bars   [16];

  // Saturating 8-bit increment for the overrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

`ifdef FFT_SEQ_PEAK_DECAY_EN
  // Bar minus DECAY, clamped at zero instead of wrapping.
  function automatic logic [MAG_W-1:0] sat0_sub(input logic [MAG_W-1:0] a);
    logic [31:0] aw;
    aw = 32'(a);
    return (aw > 32'(DECAY)) ? MAG_W'(aw - 32'(DECAY)) : '0;
  endfunction

  // Larger of two unsigned magnitudes.
  function automatic logic [MAG_W-1:0] max_mag(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
`else
  // DECAY only matters for the peak-hold build.
  logic unused_decay;
  assign unused_decay = ^32'(DECAY);
`endif

  assign vs_rise = bus.vsync & ~vsync_q;

  // Control outputs decode straight from the state register.
  assign bus.samp_start  = (state == START_SAMP);
  assign bus.fft_start   = (state == START_FFT);
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = frame_done;
  assign bus.err_timeout = err_timeout;
  assign bus.overrun_cnt = overrun_cnt;

  for (genvar k = 0; k < 16; k++) begin : g_bars
    assign bus.bars[k*MAG_W +: MAG_W] = bars[k];
  end

  // Sequencer FSM with watchdog, overrun counting and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      wd_cnt      <= '0;
      overrun_cnt <= 8'd0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      vsync_q     <= bus.vsync;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;

      // A vsync edge arriving mid-frame is dropped, only counted.
      if (vs_rise && (state != IDLE)) begin
        overrun_cnt <= sat_inc8(overrun_cnt);
      end

      case (state)
        IDLE: begin
          if (vs_rise && bus.enable) begin
            state <= START_SAMP;
          end
        end

        START_SAMP: begin
          state  <= SAMPLING;
          wd_cnt <= '0;
        end

        SAMPLING: begin
          if (bus.samp_done) begin
            state <= START_FFT;
          end else if (wd_cnt == WD_LAST) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        START_FFT: begin
          state  <= FFT;
          wd_cnt <= '0;
        end

        // fft_done takes priority over a watchdog expiry in the same cycle.
        FFT: begin
          if (bus.fft_done) begin
            state <= COMMIT;
          end else if (wd_cnt == WD_LAST) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        COMMIT: begin
          state      <= IDLE;
          frame_done <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Shadow bank collection and atomic commit into the renderer's bars.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        shadow[k] <= '0;
        bars[k]   <= '0;
      end
    end else begin
      case (state)
        START_FFT: begin
          for (int k = 0; k < 16; k++) begin
            shadow[k] <= '0;
          end
        end

        FFT: begin
          if (bus.bin_valid) begin
            shadow[bus.bin_idx] <= bus.bin_mag;
          end
        end

        COMMIT: begin
          for (int k = 0; k < 16; k++) begin
`ifdef FFT_SEQ_PEAK_DECAY_EN
            bars[k] <= max_mag(shadow[k], sat0_sub(bars[k]));
`else
            bars[k] <= shadow[k];
`endif
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fft_sequencer.sv
// Directed-plus-random bench for frame_fft_sequencer. A frame-level model
// (arrays of bar/shadow values and an overrun tally) predicts every output.
module tb_frame_fft_sequencer;

  localparam int MAG_W   = 18;
  localparam int TIMEOUT = 50;
  localparam int DECAY   = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  frame_fft_sequencer_if #(.MAG_W(MAG_W)) bus ();

  frame_fft_sequencer #(
    .MAG_W   (MAG_W),
    .TIMEOUT (TIMEOUT),
    .DECAY   (DECAY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned m_bars   [16];
  int unsigned m_shadow [16];
  int          m_ovr = 0;
  int          bq_idx [$];
  int unsigned bq_mag [$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bar(input int k);
    return 32'(bus.bars[k*MAG_W +: MAG_W]);
  endfunction

  task automatic check_bars(input string tag);
    for (int k = 0; k < 16; k++) chk($sformatf("%s[%0d]", tag, k), bar(k), m_bars[k]);
  endtask

  // Frame result per the commit rule: copy, or peak-hold with bounded fall.
  task automatic model_commit();
    for (int k = 0; k < 16; k++) begin
`ifdef FFT_SEQ_PEAK_DECAY_EN
      int unsigned fall;
      fall = (m_bars[k] > DECAY) ? m_bars[k] - DECAY : 0;
      m_bars[k] = (m_shadow[k] > fall) ? m_shadow[k] : fall;
`else
      m_bars[k] = m_shadow[k];
`endif
    end
  endtask

  task automatic apply_reset();
    bus.enable = 1'b1; bus.vsync = 1'b0; bus.samp_done = 1'b0; bus.bin_valid = 1'b0;
    bus.bin_idx = 4'd0; bus.bin_mag = '0; bus.fft_done = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    m_bars = '{default: 0}; m_shadow = '{default: 0}; m_ovr = 0;
    rst_n = 1'b1;
    tick();
  endtask

  // From IDLE: vsync rise, capture for samp_dly cycles, into FFT state.
  task automatic start_frame(input int samp_dly, input bit drop_en);
    bus.vsync = 1'b1;
    tick();
    chk("samp_start", bus.samp_start, 1);
    chk("busy_start", bus.busy, 1);
    bus.vsync = 1'b0;
    if (drop_en) bus.enable = 1'b0;
    tick();
    chk("samp_start_once", bus.samp_start, 0);
    for (int i = 0; i < samp_dly; i++) begin
      bus.bin_valid = 1'($urandom_range(0, 1));
      bus.bin_idx   = 4'($urandom_range(0, 15));
      bus.bin_mag   = MAG_W'($urandom);
      tick();
      chk("sampling_busy", bus.busy, 1);
      chk("no_fft_start_early", bus.fft_start, 0);
    end
    bus.bin_valid = 1'b0;
    bus.samp_done = 1'b1;
    tick();
    bus.samp_done = 1'b0;
    chk("fft_start", bus.fft_start, 1);
    // A bin presented while the bank is being cleared must not survive.
    bus.bin_valid = 1'b1;
    bus.bin_idx   = 4'($urandom_range(0, 15));
    bus.bin_mag   = MAG_W'($urandom_range(1, 1000));
    tick();
    bus.bin_valid = 1'b0;
    chk("fft_start_once", bus.fft_start, 0);
    m_shadow = '{default: 0};
  endtask

  // In FFT: stream the queued bins, optional extra vsync rises, then fft_done.
  task automatic stream_bins(input int n_vs_extra);
    int n;
    bit dwl;
    n   = bq_idx.size();
    dwl = (n > 0) && ($urandom_range(0, 1) == 1);
    for (int i = 0; i < n; i++) begin
      bus.bin_valid = 1'b1;
      bus.bin_idx   = 4'(bq_idx[i]);
      bus.bin_mag   = MAG_W'(bq_mag[i]);
      bus.vsync     = (i < 2 * n_vs_extra) && (i % 2 == 0);
      bus.fft_done  = dwl && (i == n - 1);
      m_shadow[bq_idx[i]] = bq_mag[i];
      tick();
    end
    bus.bin_valid = 1'b0;
    bus.vsync     = 1'b0;
    if (!dwl) begin
      bus.fft_done = 1'b1;
      tick();
    end
    bus.fft_done = 1'b0;
    m_ovr = (m_ovr + n_vs_extra > 255) ? 255 : m_ovr + n_vs_extra;
    bq_idx.delete();
    bq_mag.delete();
  endtask

  // Called right after the edge that saw fft_done.
  task automatic finish_commit();
    chk("commit_busy", bus.busy, 1);
    chk("no_early_frame_done", bus.frame_done, 0);
    check_bars("bars_hold");
    tick();
    model_commit();
    chk("frame_done", bus.frame_done, 1);
    chk("no_err_on_commit", bus.err_timeout, 0);
    check_bars("bars_commit");
    chk("overrun_cnt", bus.overrun_cnt, 32'(m_ovr));
    tick();
    chk("frame_done_once", bus.frame_done, 0);
    chk("idle_after_frame", bus.busy, 0);
  endtask

  task automatic do_frame(input int samp_dly, input int n_vs_extra, input bit drop_en);
    start_frame(samp_dly, drop_en);
    stream_bins(n_vs_extra);
    finish_commit();
  endtask

  initial begin
    #500000;
    $display("FAIL tb_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    // Reset state
    bus.enable = 1'b1; bus.vsync = 1'b0; bus.samp_done = 1'b0; bus.bin_valid = 1'b0;
    bus.bin_idx = 4'd0; bus.bin_mag = '0; bus.fft_done = 1'b0;
    tick(); tick();
    check_bars("reset_bars");
    chk("reset_busy", bus.busy, 0);
    chk("reset_samp_start", bus.samp_start, 0);
    chk("reset_fft_start", bus.fft_start, 0);
    chk("reset_frame_done", bus.frame_done, 0);
    chk("reset_err", bus.err_timeout, 0);
    chk("reset_overrun", bus.overrun_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Nominal frame: all 16 bins, shuffled order, mag 100*k
    for (int k = 0; k < 16; k++) begin bq_idx.push_back(k); bq_mag.push_back(100 * k); end
    bq_idx.shuffle();
    for (int k = 0; k < 16; k++) bq_mag[k] = 100 * bq_idx[k];
    do_frame(10, 0, 1'b0);
    chk("nominal_bar5", bar(5), 500);
    chk("nominal_bar15", bar(15), 1500);

    // Minimum-latency frame with two overrun vsync rises during FFT
    for (int k = 0; k < 6; k++) begin bq_idx.push_back(k); bq_mag.push_back($urandom_range(1, 5000)); end
    do_frame(0, 2, 1'b0);
    chk("overrun_two", bus.overrun_cnt, 2);

`ifndef FFT_SEQ_PEAK_DECAY_EN
    // Sparse + duplicate: only bin 3, written twice
    bq_idx.push_back(3); bq_mag.push_back(5);
    bq_idx.push_back(3); bq_mag.push_back(9);
    do_frame(3, 0, 1'b0);
    chk("sparse_bar3", bar(3), 9);
    chk("sparse_bar0", bar(0), 0);
    chk("sparse_bar15", bar(15), 0);
`endif

    // Enable dropped mid-frame: frame completes; then a rise in IDLE is ignored
    bq_idx.push_back(7); bq_mag.push_back(777);
    do_frame(2, 0, 1'b1);
    bus.vsync = 1'b1;
    tick();
    chk("disabled_no_samp_start", bus.samp_start, 0);
    chk("disabled_idle", bus.busy, 0);
    bus.vsync = 1'b0;
    tick();
    chk("disabled_no_overrun", bus.overrun_cnt, 32'(m_ovr));
    bus.enable = 1'b1;
    tick();

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        bq_idx.push_back($urandom_range(0, 15));
        bq_mag.push_back($urandom_range(1, (1 << MAG_W) - 1));
      end
      do_frame($urandom_range(0, 12), (n >= 4) ? $urandom_range(0, 2) : 0, 1'b0);
    end

    // Watchdog in SAMPLING: samp_done never comes
    bus.vsync = 1'b1;
    tick();
    chk("wd_samp_start", bus.samp_start, 1);
    bus.vsync = 1'b0;
    tick();
    for (int i = 1; i < TIMEOUT; i++) tick();
    chk("wd_not_yet", bus.err_timeout, 0);
    chk("wd_still_busy", bus.busy, 1);
    tick();
    chk("wd_err_pulse", bus.err_timeout, 1);
    chk("wd_idle", bus.busy, 0);
    chk("wd_no_frame_done", bus.frame_done, 0);
    check_bars("wd_bars_kept");
    tick();
    chk("wd_err_once", bus.err_timeout, 0);

    // Watchdog in FFT after some bins: bars kept, shadow discarded
    start_frame(1, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      bus.bin_valid = (i < 2);
      bus.bin_idx   = 4'(i);
      bus.bin_mag   = MAG_W'(60000 + i);
      tick();
    end
    bus.bin_valid = 1'b0;
    chk("wd_fft_not_yet", bus.err_timeout, 0);
    tick();
    chk("wd_fft_err", bus.err_timeout, 1);
    chk("wd_fft_idle", bus.busy, 0);
    check_bars("wd_fft_bars_kept");
    tick();
    do_frame(1, 0, 1'b0);   // no bins: abandoned shadow must not appear

    // fft_done coincident with watchdog expiry commits the frame
    start_frame(2, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      bus.bin_valid = (i == 0);
      bus.bin_idx   = 4'd9;
      bus.bin_mag   = MAG_W'(4321);
      tick();
    end
    bus.bin_valid = 1'b0;
    m_shadow[9] = 4321;
    bus.fft_done = 1'b1;
    tick();
    bus.fft_done = 1'b0;
    chk("race_no_err", bus.err_timeout, 0);
    finish_commit();

`ifdef FFT_SEQ_PEAK_DECAY_EN
    // Peak hold with bounded fall
    apply_reset();
    bq_idx.push_back(0); bq_mag.push_back(1000); do_frame(1, 0, 1'b0);
    chk("decay_bar0_1000", bar(0), 1000);
    bq_idx.push_back(0); bq_mag.push_back(0); do_frame(1, 0, 1'b0);
    chk("decay_bar0_744", bar(0), 744);
    bq_idx.push_back(0); bq_mag.push_back(2000); do_frame(1, 0, 1'b0);
    chk("decay_bar0_2000", bar(0), 2000);
    apply_reset();
    bq_idx.push_back(0); bq_mag.push_back(100); do_frame(1, 0, 1'b0);
    chk("decay_bar0_100", bar(0), 100);
    bq_idx.push_back(0); bq_mag.push_back(0); do_frame(1, 0, 1'b0);
    chk("decay_bar0_floor", bar(0), 0);
`endif

    // Overrun saturation: toggle vsync through repeated capture timeouts
    for (int r = 0; r < 12; r++) begin
      bus.vsync = 1'b1;
      tick();
      bus.vsync = 1'b0;
      tick();
      for (int j = 1; j < TIMEOUT; j++) begin
        bus.vsync = (j <= 48) && (j % 2 == 1);
        tick();
      end
      bus.vsync = 1'b0;
      tick();
      m_ovr = (m_ovr + 24 > 255) ? 255 : m_ovr + 24;
      chk("sat_err", bus.err_timeout, 1);
      chk("sat_overrun", bus.overrun_cnt, 32'(m_ovr));
      tick();
    end
    chk("overrun_saturated", bus.overrun_cnt, 255);

    // Asynchronous reset mid-FFT with nonzero bars
    bq_idx.push_back(4); bq_mag.push_back(1234);
    do_frame(1, 0, 1'b0);
    start_frame(1, 1'b0);
    bus.bin_valid = 1'b1; bus.bin_idx = 4'd2; bus.bin_mag = MAG_W'(999);
    tick();
    bus.bin_valid = 1'b0;
    chk("pre_reset_bar4", bar(4), 32'(m_bars[4]));
    #2 rst_n = 1'b0;
    #1;
    m_bars = '{default: 0}; m_shadow = '{default: 0}; m_ovr = 0;
    check_bars("async_reset_bars");
    chk("async_reset_idle", bus.busy, 0);
    chk("async_reset_overrun", bus.overrun_cnt, 0);
    chk("async_reset_no_pulse", bus.frame_done | bus.err_timeout | bus.samp_start | bus.fft_start, 0);
    tick();
    rst_n = 1'b1;
    tick();
    bq_idx.push_back(1); bq_mag.push_back(55);
    do_frame(2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
